display_mode_ctrl: RTL
======================

Name: display_mode_ctrl

Overview:
- Upstream controller for the 8-digit display mux.
- Generates the 2-bit mode selector (00 blank, 01 flowing, 10 VIP, 11 static) and the VIP-page BCD fields id1/id0/remain1/remain0.
- Runs a per-second BCD countdown of the VIP session. Drops back to flowing mode on expiry or abort.
- Button inputs are already debounced single-cycle pulses.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per countdown step (1 s at 100 MHz); benches override to a small value such as 4.
- DEFAULT_REMAIN, 8'h30, BCD session length loaded when sw_time is zero or not valid BCD.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- btn_next  input  1  one-cycle pulse; advance or abort mode
- btn_vip  input  1  one-cycle pulse; start or restart VIP session
- sw_id  input  8  BCD VIP id; [7:4] tens, [3:0] units
- sw_time  input  8  BCD session length; [7:4] tens, [3:0] units
- mode  output  2  selector to display mux
- id1  output  4  VIP id tens digit
- id0  output  4  VIP id units digit
- remain1  output  4  remaining-time tens digit
- remain0  output  4  remaining-time units digit
- expired  output  1  one-cycle pulse when a session counts down to 00

Behaviour:
- Reset (rst low, asynchronous):
  - state OFF, mode=00.
  - id1, id0, remain1, remain0 = 0.
  - expired=0, tick counter=0.
  - All outputs are registered; mode equals the state encoding.
- States and transitions. All transitions take effect on the clock edge after the pulse; outputs update the same edge.
  - OFF (00): btn_next or btn_vip -> FLOW. btn_vip from OFF does not start a session.
  - FLOW (01): btn_next -> STATIC. btn_vip -> VIP with load.
  - STATIC (11): btn_next -> FLOW. btn_vip -> VIP with load.
  - VIP (10):
    - btn_next -> FLOW (abort): remain and id cleared to 0, expired stays 0.
    - btn_vip -> reload: re-latch id and time, tick counter cleared, stay in VIP.
- Simultaneous btn_next and btn_vip: btn_next wins and btn_vip is ignored.
- Load:
  - id1/id0 latch sw_id. Any digit >9 is clamped to 9.
  - remain1/remain0 latch sw_time. If sw_time is 8'h00 or either nibble >9, DEFAULT_REMAIN is loaded instead.
  - Tick counter is cleared to 0.
- Countdown, VIP only:
  - Tick counter runs 0..TICK_CYCLES-1 and wraps.
  - On the wrap cycle, remain is decremented in BCD:
    - remain0>0: remain0-1.
    - remain0=0: remain0=9 and remain1-1.
  - First decrement occurs TICK_CYCLES cycles after the load edge.
  - Counter is held at 0 outside VIP.
- Expiry: on a wrap cycle with remain==01:
  - remain becomes 00, id cleared to 0, state -> FLOW.
  - expired=1 for exactly that one cycle.
- Button versus wrap in the same cycle: the button action wins, and no decrement or expiry occurs that cycle.
- Reset mid-session: immediate return to OFF with all fields zero. expired is never asserted by reset.
- remain never underflows; 00 is never held in VIP.

Test Plan:
- Reset check: rst low, then high. Required: mode=00, all digits 0, expired=0. One btn_next pulse -> mode=01 next edge. A second btn_next -> mode=11; a third -> mode=01.
- Countdown and expiry (TICK_CYCLES=4): from FLOW, sw_id=8'h27, sw_time=8'h02, pulse btn_vip.
  - Required: mode=10, id=2/7, remain=0/2.
  - After 4 cycles remain=0/1.
  - After 8 cycles remain=0/0, mode=01, id=0/0, expired high for exactly 1 cycle.
- BCD borrow (TICK_CYCLES=4): sw_time=8'h10, start VIP. Required: after 4 cycles remain=0/9; after 8 cycles remain=0/8.
- Invalid inputs: sw_id=8'hA3 and sw_time=8'h1F, pulse btn_vip. Required: id=9/3, remain=3/0 (DEFAULT_REMAIN). Repeat with sw_time=8'h00: remain=3/0.
- Abort, priority and reset (TICK_CYCLES=4):
  - In VIP with remain=0/5, pulse btn_next and btn_vip together. Required: mode=01, remain=0/0, expired=0.
  - Restart VIP, then pulse btn_vip on the wrap cycle. Required: reload, no decrement.
  - Drop rst low mid-session. Required: mode=00 asynchronously, all fields zero.

Source files
------------

// File: rtl/display_mode_ctrl.sv
// Mode selector and VIP-page BCD fields for the 8-digit display mux.
// Holds a per-second BCD countdown while a VIP session runs.
module display_mode_ctrl #(
  parameter int unsigned TICK_CYCLES    = 100000000,
  parameter logic [7:0]  DEFAULT_REMAIN = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_vip,
  input  logic [7:0] sw_id,
  input  logic [7:0] sw_time,
  output logic [1:0] mode,
  output logic [3:0] id1,
  output logic [3:0] id0,
  output logic [3:0] remain1,
  output logic [3:0] remain0,
  output logic       expired
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_FLOW   = 2'b01,
    S_VIP    = 2'b10,
    S_STATIC = 2'b11
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic [3:0]    id1_q, id0_q, remain1_q, remain0_q;
  logic          expired_q;

  logic [3:0]    load_id1_d, load_id0_d;
  logic [7:0]    load_remain_d;
  logic          time_ok;

  assign load_id1_d    = (sw_id[7:4] > 4'd9) ? 4'd9 : sw_id[7:4];
  assign load_id0_d    = (sw_id[3:0] > 4'd9) ? 4'd9 : sw_id[3:0];
  assign time_ok       = (sw_time != 8'h00) && (sw_time[7:4] <= 4'd9) && (sw_time[3:0] <= 4'd9);
  assign load_remain_d = time_ok ? sw_time : DEFAULT_REMAIN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_OFF;
      tick_q    <= '0;
      id1_q     <= '0;
      id0_q     <= '0;
      remain1_q <= '0;
      remain0_q <= '0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          if (btn_next || btn_vip) state_q <= S_FLOW;
        end
        S_FLOW, S_STATIC: begin
          if (btn_next) begin
            state_q <= (state_q == S_FLOW) ? S_STATIC : S_FLOW;
          end else if (btn_vip) begin
            state_q   <= S_VIP;
            id1_q     <= load_id1_d;
            id0_q     <= load_id0_d;
            remain1_q <= load_remain_d[7:4];
            remain0_q <= load_remain_d[3:0];
            tick_q    <= '0;
          end
        end
        S_VIP: begin
          // Buttons take precedence over a coincident wrap.
          if (btn_next) begin
            state_q   <= S_FLOW;
            id1_q     <= '0;
            id0_q     <= '0;
            remain1_q <= '0;
            remain0_q <= '0;
            tick_q    <= '0;
          end else if (btn_vip) begin
            id1_q     <= load_id1_d;
            id0_q     <= load_id0_d;
            remain1_q <= load_remain_d[7:4];
            remain0_q <= load_remain_d[3:0];
            tick_q    <= '0;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (remain1_q == 4'd0 && remain0_q == 4'd1) begin
              state_q   <= S_FLOW;
              remain0_q <= '0;
              id1_q     <= '0;
              id0_q     <= '0;
              expired_q <= 1'b1;
            end else if (remain0_q != 4'd0) begin
              remain0_q <= remain0_q - 4'd1;
            end else begin
              remain0_q <= 4'd9;
              remain1_q <= remain1_q - 4'd1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign mode    = state_q;
  assign id1     = id1_q;
  assign id0     = id0_q;
  assign remain1 = remain1_q;
  assign remain0 = remain0_q;
  assign expired = expired_q;

endmodule
